// File: rtl/ft2232h_pkg.sv
// Shared FT2232H bus types and transmit-state encoding.
// Used by both the transmit and receive sides of the bridge.
package ft2232h_pkg;

    localparam int BUS_W = 8;

    typedef logic [BUS_W-1:0] bus_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/ft2232h_tx_fifo.sv
// Synchronous byte FIFO with first-word lookahead.
// Also exposes the entry behind the head for back-to-back writes.
module ft2232h_tx_fifo
    import ft2232h_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  bus_byte_t                push_data,
    input  logic                     pop,
    output bus_byte_t                head,
    output bus_byte_t                next,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    bus_byte_t         mem [DEPTH];
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr_nx;

    assign rptr_nx = rptr + 1'b1;
    assign head    = mem[rptr];
    assign next    = mem[rptr_nx];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr_nx;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ft2232h_tx.sv
// FT2232H synchronous-FIFO transmit side: buffer, WR# sequencer
// and send-immediate (SIWU#) flush after a drained burst.
module ft2232h_tx
    import ft2232h_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SIWU_IDLE = 64
) (
    input  logic                     clkout_i,
    input  logic                     rst_n_i,
    input  logic [7:0]               in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     txe_n_i,
    input  logic                     rx_active_i,
    output logic                     wr_n_o,
    output logic [7:0]               data_o,
    output logic                     data_oe_o,
    output logic                     siwu_n_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(SIWU_IDLE + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE  = LW'(1);
    localparam logic [CW-1:0] LAST = CW'(SIWU_IDLE - 1);

    tx_state_t  state, state_d;
    logic       wr_n_d, oe_d;
    bus_byte_t  data_d;
    bus_byte_t  head, next;
    logic       push, commit, remain;
    bus_byte_t  after_head;
    logic       flush_armed;
    logic [CW-1:0] idle_cnt;

    assign in_ready_o = (level_o < FULL);
    assign push       = in_valid_i & in_ready_o;
    assign commit     = ~wr_n_o & ~txe_n_i;

    // A lone byte being popped can still chain if a new one arrives now
    assign remain     = (level_o > ONE) | ((level_o == ONE) & push);
    assign after_head = (level_o > ONE) ? next : in_data_i;

    ft2232h_tx_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clkout_i),
        .rst_n     (rst_n_i),
        .push      (push),
        .push_data (in_data_i),
        .pop       (commit),
        .head      (head),
        .next      (next),
        .level     (level_o)
    );

    always_comb begin
        state_d = state;
        wr_n_d  = wr_n_o;
        oe_d    = data_oe_o;
        data_d  = data_o;
        unique case (state)
            ST_IDLE: begin
                wr_n_d = 1'b1;
                oe_d   = 1'b0;
                if ((level_o != '0) && !txe_n_i && !rx_active_i) begin
                    state_d = ST_WRITE;
                    wr_n_d  = 1'b0;
                    oe_d    = 1'b1;
                    data_d  = head;
                end
            end
            ST_WRITE: begin
                if (commit && remain && !rx_active_i) begin
                    data_d = after_head;
                end else if (commit || rx_active_i) begin
                    state_d = ST_IDLE;
                    wr_n_d  = 1'b1;
                    oe_d    = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                    wr_n_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (rx_active_i) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end else if (!txe_n_i) begin
                    state_d = ST_WRITE;
                    wr_n_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wr_n_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            wr_n_o    <= 1'b1;
            data_oe_o <= 1'b0;
            data_o    <= '0;
        end else begin
            state     <= state_d;
            wr_n_o    <= wr_n_d;
            data_oe_o <= oe_d;
            data_o    <= data_d;
        end
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flush_armed <= 1'b0;
            idle_cnt    <= '0;
            siwu_n_o    <= 1'b1;
        end else begin
            siwu_n_o <= 1'b1;
            if (commit) begin
                flush_armed <= 1'b1;
            end
            if (push) begin
                idle_cnt <= '0;
            end else if (state == ST_IDLE && level_o == '0 && flush_armed) begin
                if (idle_cnt == LAST) begin
                    siwu_n_o    <= 1'b0;
                    idle_cnt    <= '0;
                    flush_armed <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
